// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - MEM/WB pipeline-register fields consumed by the writeback stage
//
// Purpose: bundles the control and data fields presented by the MEM/WB
// pipeline register so they travel as one port.
//
// Signals:
//   reg_write        write enable for this slot
//   mem_or_reg       1 = commit memory data, 0 = commit ALU result
//   dest_or_private  0 = general-purpose bank, 1 = private bank
//   i_am_bubble      slot carries no instruction
//   reg_dest_address destination register address (4 bits)
//   data_res         ALU result
//   data             memory read data
//
// Modports: master drives the fields (MEM/WB register), slave consumes them.

interface writeback_regfile_if #(
  parameter int DATA_W = 16
);
  logic              reg_write;
  logic              mem_or_reg;
  logic              dest_or_private;
  logic              i_am_bubble;
  logic [3:0]        reg_dest_address;
  logic [DATA_W-1:0] data_res;
  logic [DATA_W-1:0] data;

  modport master (
    output reg_write,
    output mem_or_reg,
    output dest_or_private,
    output i_am_bubble,
    output reg_dest_address,
    output data_res,
    output data
  );

  modport slave (
    input reg_write,
    input mem_or_reg,
    input dest_or_private,
    input i_am_bubble,
    input reg_dest_address,
    input data_res,
    input data
  );
endinterface

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage, architectural register file and retire counter
//
// Purpose: selects the memory or ALU result of the MEM/WB slot, commits it
// to the general-purpose or private bank on the rising edge, serves the
// decode read ports, publishes a registered record of the last committed
// write for the forwarding unit, and counts retired (non-bubble) slots.
//
// Optional feature: define WB_BYPASS_EN to let the read ports return the
// value being committed in the same cycle when the addresses match.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   wb             MEM/WB fields (writeback_regfile_if.slave)
//   rd_addr_a/b    decode GPR read addresses
//   rd_data_a/b    decode GPR read data (combinational)
//   priv_rd_addr   private-bank read address
//   priv_rd_data   private-bank read data (combinational)
//   fwd_valid      a write was committed on the last edge
//   fwd_private    bank of that write
//   fwd_addr       full destination address of that write
//   fwd_data       value committed
//   retire_count   non-bubble slots since reset (wraps)

module writeback_regfile #(
  parameter int                   DATA_W   = 16,
  parameter int                   GPR_N    = 8,
  parameter int                   PRIV_N   = 4,
  parameter logic [DATA_W-1:0]    SP_RESET = 16'h07FF
) (
  input  logic                     clk,
  input  logic                     rst,
  writeback_regfile_if.slave       wb,
  input  logic [2:0]               rd_addr_a,
  input  logic [2:0]               rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  input  logic [1:0]               priv_rd_addr,
  output logic [DATA_W-1:0]        priv_rd_data,
  output logic                     fwd_valid,
  output logic                     fwd_private,
  output logic [3:0]               fwd_addr,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [15:0]              retire_count
);

  // Register arrays
  logic [DATA_W-1:0] gpr_q  [GPR_N];
  logic [DATA_W-1:0] gpr_d  [GPR_N];
  logic [DATA_W-1:0] priv_q [PRIV_N];
  logic [DATA_W-1:0] priv_d [PRIV_N];

  // Forwarding record
  logic              fwd_valid_q,   fwd_valid_d;
  logic              fwd_private_q, fwd_private_d;
  logic [3:0]        fwd_addr_q,    fwd_addr_d;
  logic [DATA_W-1:0] fwd_data_q,    fwd_data_d;

  logic [15:0]       retire_count_q, retire_count_d;

  logic [DATA_W-1:0] wb_sel;
  logic              commit;
  logic              commit_gpr;
  logic              commit_priv;
  logic [2:0]        gpr_waddr;
  logic [1:0]        priv_waddr;

  // Commit qualification. Masking with rst here also masks the bypass,
  // so a write arriving during reset is invisible everywhere.
  always_comb begin
    wb_sel      = wb.mem_or_reg ? wb.data : wb.data_res;
    commit      = wb.reg_write & ~wb.i_am_bubble & ~rst;
    commit_gpr  = commit & ~wb.dest_or_private;
    commit_priv = commit &  wb.dest_or_private;
    // Upper address bits are ignored by the array but kept in fwd_addr.
    gpr_waddr   = wb.reg_dest_address[2:0];
    priv_waddr  = wb.reg_dest_address[1:0];
  end

  // Next-state for the arrays
  always_comb begin
    for (int i = 0; i < GPR_N; i++) begin
      gpr_d[i] = gpr_q[i];
    end
    for (int i = 0; i < PRIV_N; i++) begin
      priv_d[i] = priv_q[i];
    end
    if (commit_gpr) begin
      gpr_d[gpr_waddr] = wb_sel;
    end
    if (commit_priv) begin
      priv_d[priv_waddr] = wb_sel;
    end
  end

  // Next-state for the forwarding record: valid pulses for one cycle per
  // commit, payload holds between commits.
  always_comb begin
    fwd_valid_d   = commit;
    fwd_private_d = fwd_private_q;
    fwd_addr_d    = fwd_addr_q;
    fwd_data_d    = fwd_data_q;
    if (commit) begin
      fwd_private_d = wb.dest_or_private;
      fwd_addr_d    = wb.reg_dest_address;
      fwd_data_d    = wb_sel;
    end
  end

  // Stores and branches retire too, so reg_write is deliberately not used.
  always_comb begin
    retire_count_d = retire_count_q;
    if (!wb.i_am_bubble) begin
      retire_count_d = retire_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GPR_N; i++) begin
        gpr_q[i] <= '0;
      end
      for (int i = 0; i < PRIV_N; i++) begin
        priv_q[i] <= '0;
      end
      // Private register 0 is the stack pointer.
      priv_q[0]      <= SP_RESET;
      fwd_valid_q    <= 1'b0;
      fwd_private_q  <= 1'b0;
      fwd_addr_q     <= 4'd0;
      fwd_data_q     <= '0;
      retire_count_q <= 16'd0;
    end else begin
      for (int i = 0; i < GPR_N; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      for (int i = 0; i < PRIV_N; i++) begin
        priv_q[i] <= priv_d[i];
      end
      fwd_valid_q    <= fwd_valid_d;
      fwd_private_q  <= fwd_private_d;
      fwd_addr_q     <= fwd_addr_d;
      fwd_data_q     <= fwd_data_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Read ports
  always_comb begin
    rd_data_a    = gpr_q[rd_addr_a];
    rd_data_b    = gpr_q[rd_addr_b];
    priv_rd_data = priv_q[priv_rd_addr];
`ifdef WB_BYPASS_EN
    if (commit_gpr && (gpr_waddr == rd_addr_a)) begin
      rd_data_a = wb_sel;
    end
    if (commit_gpr && (gpr_waddr == rd_addr_b)) begin
      rd_data_b = wb_sel;
    end
    if (commit_priv && (priv_waddr == priv_rd_addr)) begin
      priv_rd_data = wb_sel;
    end
`endif
  end

  assign fwd_valid    = fwd_valid_q;
  assign fwd_private  = fwd_private_q;
  assign fwd_addr     = fwd_addr_q;
  assign fwd_data     = fwd_data_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile

module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [1:0]  priv_rd_addr;
  logic [15:0] priv_rd_data;
  logic        fwd_valid;
  logic        fwd_private;
  logic [3:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic [15:0] retire_count;

  writeback_regfile_if #(.DATA_W(16)) wb_bus ();

  writeback_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wb_bus),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .priv_rd_addr (priv_rd_addr),
    .priv_rd_data (priv_rd_data),
    .fwd_valid    (fwd_valid),
    .fwd_private  (fwd_private),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic        priv;
    logic [3:0]  addr;
    logic [15:0] data;
  } fwd_t;

  fwd_t        fwd_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        mon_en   = 1'b0;
  logic [15:0] exp_retire = 16'd0;

  // Forwarding monitor: every committed write must show up exactly once,
  // in order, as a fwd_valid cycle.
  always @(negedge clk) begin
    if (mon_en && fwd_valid) begin
      checks++;
      if (fwd_q.size() == 0) begin
        failures++;
        $display("FAIL fwd_unexpected actual addr=%h data=%h required no fwd_valid", fwd_addr, fwd_data);
      end else begin
        fwd_t e;
        e = fwd_q.pop_front();
        if ({fwd_private, fwd_addr, fwd_data} !== e) begin
          failures++;
          $display("FAIL fwd_record actual priv=%b addr=%h data=%h required priv=%b addr=%h data=%h",
                   fwd_private, fwd_addr, fwd_data, e.priv, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one edge; the retire model looks at the inputs about to be sampled.
  task automatic step();
    if (rst) exp_retire = 16'd0;
    else if (!wb_bus.i_am_bubble) exp_retire = exp_retire + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_bus.reg_write        = 1'b0;
    wb_bus.mem_or_reg       = 1'b0;
    wb_bus.dest_or_private  = 1'b0;
    wb_bus.i_am_bubble      = 1'b0;
    wb_bus.reg_dest_address = 4'h0;
    wb_bus.data_res         = 16'h0;
    wb_bus.data             = 16'h0;
  endtask

  task automatic drive_write(input logic dop, input logic mor, input logic [3:0] dest,
                             input logic [15:0] dres, input logic [15:0] dmem,
                             input logic [15:0] exp_val);
    wb_bus.reg_write        = 1'b1;
    wb_bus.mem_or_reg       = mor;
    wb_bus.dest_or_private  = dop;
    wb_bus.i_am_bubble      = 1'b0;
    wb_bus.reg_dest_address = dest;
    wb_bus.data_res         = dres;
    wb_bus.data             = dmem;
    fwd_q.push_back({dop, dest, exp_val});
  endtask

  task automatic rd_gpr(input string name, input logic [2:0] a, input logic [15:0] exp);
    rd_addr_a = a;
    #1;
    check(name, {16'h0, rd_data_a}, {16'h0, exp});
  endtask

  task automatic rd_priv(input string name, input logic [1:0] a, input logic [15:0] exp);
    priv_rd_addr = a;
    #1;
    check(name, {16'h0, priv_rd_data}, {16'h0, exp});
  endtask

  initial begin
    rd_addr_a    = 3'd0;
    rd_addr_b    = 3'd0;
    priv_rd_addr = 2'd0;
    idle();

    // Reset, with a concurrent write that must be ignored
    rst = 1'b1;
    drive_write(1'b0, 1'b0, 4'h1, 16'h1234, 16'h0, 16'h0);
    void'(fwd_q.pop_back());
    step();
    rst = 1'b0;
    idle();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) rd_gpr("reset_gpr", i[2:0], 16'h0000);
    check("reset_retire", {16'h0, retire_count}, 32'h0);
    check("reset_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    step();
    rd_priv("reset_sp", 2'd0, 16'h07FF);
    rd_priv("reset_priv1", 2'd1, 16'h0000);
    rd_priv("reset_priv3", 2'd3, 16'h0000);

    // ALU write to GPR3
    drive_write(1'b0, 1'b0, 4'h3, 16'hA5A5, 16'h1111, 16'hA5A5);
    step();
    idle();
    rd_gpr("alu_gpr3", 3'd3, 16'hA5A5);
    check("alu_fwd_valid", {31'h0, fwd_valid}, 32'h1);
    step();
    check("alu_fwd_drop", {31'h0, fwd_valid}, 32'h0);
    check("alu_fwd_hold", {16'h0, fwd_data}, 32'hA5A5);

    // Memory write to private bank, address E -> PRIV2
    drive_write(1'b1, 1'b1, 4'hE, 16'h5555, 16'h0123, 16'h0123);
    step();
    idle();
    rd_priv("mem_priv2", 2'd2, 16'h0123);
    rd_gpr("mem_gpr6", 3'd6, 16'h0000);
    rd_priv("mem_sp", 2'd0, 16'h07FF);
    step();

    // Bubble with reg_write set
    wb_bus.reg_write        = 1'b1;
    wb_bus.i_am_bubble      = 1'b1;
    wb_bus.reg_dest_address = 4'h5;
    wb_bus.data_res         = 16'hFFFF;
    check("pre_bubble_retire", {16'h0, retire_count}, {16'h0, exp_retire});
    step();
    idle();
    rd_gpr("bubble_gpr5", 3'd5, 16'h0000);
    check("bubble_retire", {16'h0, retire_count}, {16'h0, exp_retire});
    check("bubble_fwd_valid", {31'h0, fwd_valid}, 32'h0);

    // Back-to-back writes to GPR2, bit 3 of the address ignored by the array
    drive_write(1'b0, 1'b0, 4'h2, 16'h1111, 16'h0, 16'h1111);
    step();
    drive_write(1'b0, 1'b1, 4'hA, 16'h0, 16'h2222, 16'h2222);
    step();
    drive_write(1'b0, 1'b0, 4'h8, 16'h00AA, 16'h0, 16'h00AA);
    step();
    drive_write(1'b0, 1'b0, 4'h1, 16'h9999, 16'h0, 16'h9999);
    step();
    idle();
    rd_gpr("b2b_gpr2", 3'd2, 16'h2222);
    rd_gpr("gpr0_write", 3'd0, 16'h00AA);
    rd_gpr("gpr1_write", 3'd1, 16'h9999);

    // Same-cycle visibility on GPR7 and PRIV3
    drive_write(1'b0, 1'b0, 4'h7, 16'h7777, 16'h0, 16'h7777);
    step();
    drive_write(1'b0, 1'b0, 4'h7, 16'hBEEF, 16'h0, 16'hBEEF);
    rd_addr_b = 3'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("bypass_same_cycle", {16'h0, rd_data_b}, 32'hBEEF);
`else
    check("nobypass_same_cycle", {16'h0, rd_data_b}, 32'h7777);
`endif
    step();
    drive_write(1'b1, 1'b0, 4'h3, 16'hCAFE, 16'h0, 16'hCAFE);
    priv_rd_addr = 2'd3;
    #1;
    check("gpr7_next_cycle_b", {16'h0, rd_data_b}, 32'hBEEF);
`ifdef WB_BYPASS_EN
    check("priv_bypass_same_cycle", {16'h0, priv_rd_data}, 32'hCAFE);
`else
    check("priv_nobypass_same_cycle", {16'h0, priv_rd_data}, 32'h0000);
`endif
    step();
    idle();
    rd_gpr("gpr7_next_cycle_a", 3'd7, 16'hBEEF);
    rd_priv("priv3_next_cycle", 2'd3, 16'hCAFE);
    check("retire_running", {16'h0, retire_count}, {16'h0, exp_retire});

    // Counter wrap (loop ends when the model reaches FFFF)
    while (exp_retire != 16'hFFFF) step();
    check("retire_ffff", {16'h0, retire_count}, 32'hFFFF);
    step();
    check("retire_wrap", {16'h0, retire_count}, 32'h0000);

    // Reset overrides a concurrent commit to GPR1
    rst = 1'b1;
    wb_bus.reg_write        = 1'b1;
    wb_bus.reg_dest_address = 4'h1;
    wb_bus.data_res         = 16'h4321;
    step();
    rst = 1'b0;
    idle();
    rd_gpr("rst_prio_gpr1", 3'd1, 16'h0000);
    rd_priv("rst_prio_priv2", 2'd2, 16'h0000);
    rd_priv("rst_prio_sp", 2'd0, 16'h07FF);
    check("rst_prio_retire", {16'h0, retire_count}, 32'h0);
    check("rst_prio_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    check("rst_prio_fwd_data", {16'h0, fwd_data}, 32'h0);
    step();
    check("retire_after_reset", {16'h0, retire_count}, 32'h1);

    @(negedge clk);
    #1;
    check("fwd_queue_drained", fwd_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file at the consumer end of the MEM/WB pipeline register. Each cycle it takes the MEM/WB control and data fields, selects memory or ALU result, and commits it on the rising edge to a general-purpose or private register unless the slot is a bubble. It also serves the decode stage's read ports, publishes a registered record of the last committed write for the forwarding unit, and counts retired instructions.

## Interface
Parameters:
- DATA_W, 16, register and data width
- GPR_N, 8, general-purpose registers, indexed by `reg_dest_address[2:0]`
- PRIV_N, 4, private registers, indexed by `reg_dest_address[1:0]`
- SP_RESET, 16'h07FF, reset value of private register 0 (stack pointer)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reg_write  in  1  MEM/WB write enable
- mem_or_reg  in  1  1 = commit `data` (memory), 0 = commit `data_res` (ALU)
- dest_or_private  in  1  0 = GPR bank, 1 = private bank
- i_am_bubble  in  1  slot is a bubble; suppresses write and retire count
- reg_dest_address  in  4  destination address
- data_res  in  DATA_W  ALU result
- data  in  DATA_W  memory read data
- rd_addr_a, rd_addr_b  in  3  decode GPR read addresses
- rd_data_a, rd_data_b  out  DATA_W  decode GPR read data (combinational)
- priv_rd_addr  in  2  private-bank read address
- priv_rd_data  out  DATA_W  private-bank read data (combinational)
- fwd_valid  out  1  a write was committed on the last edge
- fwd_private  out  1  bank of that write
- fwd_addr  out  4  full `reg_dest_address` of that write
- fwd_data  out  DATA_W  value committed
- retire_count  out  16  non-bubble slots since reset

## Operation
- wb_sel = mem_or_reg ? data : data_res.
- commit = reg_write & ~i_am_bubble & ~rst.
- On commit with dest_or_private=0: GPR[reg_dest_address[2:0]] <= wb_sel; bit 3 ignored. With dest_or_private=1: PRIV[reg_dest_address[1:0]] <= wb_sel; bits 3:2 ignored.
- GPR0 is an ordinary writable register.
- Forwarding record: every edge, fwd_valid <= commit; when commit, fwd_private/fwd_addr/fwd_data are loaded; when not, they hold their previous values.
- retire_count increments by 1 on every edge where i_am_bubble=0 and rst=0, independent of reg_write (stores/branches retire); wraps 16'hFFFF -> 16'h0000.
- Read ports are pure muxes over the register arrays plus optional bypass (see Configuration); no read side effects.

## Timing
- Reset (sampled at edge): all GPRs 0; PRIV0 = SP_RESET, PRIV1..3 = 0; fwd_valid=0, fwd_private=0, fwd_addr=0, fwd_data=0; retire_count=0. Reset overrides any concurrent commit.
- Write latency: value presented in cycle N is visible in the array (and on non-bypassed reads) from cycle N+1; fwd_* reflect it during cycle N+1 only (fwd_valid drops in N+2 unless another commit).
- Bubble with reg_write=1: no write, fwd_valid=0 next cycle, counter holds.
- Back-to-back writes to the same address: last one wins, one per cycle, no stall.
- Inputs are sampled only at the rising edge; mid-cycle input changes have no effect.
- Reset deasserted at edge N: first commit possible at edge N+1.

## Configuration
- WB_BYPASS_EN defined: if commit is active and dest_or_private=0 and reg_dest_address[2:0] equals rd_addr_a (or rd_addr_b), that port returns wb_sel in the same cycle; same for private bank vs priv_rd_addr with dest_or_private=1. Bypass is masked while rst=1.
- Undefined: read ports always return the stored array value; the same-cycle write is visible only from the next cycle.

## Test plan
- Reset: assert rst 1 cycle -> all rd_data=0, priv_rd_data at addr 0 = 16'h07FF, retire_count=0, fwd_valid=0.
- ALU write: reg_write=1, mem_or_reg=0, dest 4'h3, data_res=16'hA5A5, data=16'h1111 -> next cycle rd_addr_a=3 reads 16'hA5A5; fwd_valid=1, fwd_addr=3, fwd_data=16'hA5A5; following cycle fwd_valid=0.
- Memory write to private: dest_or_private=1, mem_or_reg=1, dest 4'hE, data=16'h0123 -> PRIV2=16'h0123, GPR6 unchanged.
- Bubble: reg_write=1, i_am_bubble=1, dest 5, data_res=16'hFFFF -> GPR5 unchanged, retire_count unchanged, fwd_valid=0.
- Bypass: write 16'hBEEF to GPR7 while rd_addr_b=7 -> same cycle rd_data_b=16'hBEEF with WB_BYPASS_EN, old value without; both 16'hBEEF next cycle.
- Counter wrap + reset priority: preload 65535 non-bubble cycles, one more -> retire_count=0; rst with concurrent commit to GPR1 -> GPR1=0.
